// File: rtl/flash_pkg.sv
// Shared types and constants for the flash command arbiter.
package flash_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WREN = 3'd1,
    ST_WGAP = 3'd2,
    ST_CMD  = 3'd3,
    ST_GAP  = 3'd4
  } state_t;

  localparam logic [3:0] CT_IDLE = 4'b0000;
  localparam logic [3:0] CT_CMD  = 4'b1001;
  localparam logic [3:0] CT_PROG = 4'b1101;

  localparam logic [7:0] OP_WREN = 8'h06;
  localparam logic [7:0] OP_PP   = 8'h02;
  localparam logic [7:0] OP_SE   = 8'h20;
  localparam logic [7:0] OP_BE   = 8'hD8;
  localparam logic [7:0] OP_CE   = 8'hC7;
  localparam logic [7:0] OP_READ = 8'h03;

  // Program and erase opcodes must be preceded by Write Enable.
  function automatic logic needs_wren(input logic [7:0] op);
    return (op == OP_PP) || (op == OP_SE) || (op == OP_BE) || (op == OP_CE);
  endfunction

endpackage

// File: rtl/flash_cmd_arbiter_if.sv
// Command bus between the arbiter (master) and flash_spi (slave).
interface flash_cmd_arbiter_if;
  logic [3:0]  spi_cmd_type;
  logic [7:0]  spi_cmd;
  logic [23:0] spi_addr;
  logic        spi_done;
  logic [7:0]  spi_rdata;
  logic        spi_rvalid;

  modport master (
    output spi_cmd_type, spi_cmd, spi_addr,
    input  spi_done, spi_rdata, spi_rvalid
  );

  modport slave (
    input  spi_cmd_type, spi_cmd, spi_addr,
    output spi_done, spi_rdata, spi_rvalid
  );
endinterface

// File: rtl/flash_rr_pick.sv
// Two-way round-robin pick: a lone request wins, a tie goes to the port
// that was not granted last time.
module flash_rr_pick (
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant_idx
);

  // Combinational grant decision.
  always_comb begin
    grant_valid = req0 | req1;
    grant_idx   = (req0 & req1) ? ~last_grant : req1;
  end

endmodule

// File: rtl/flash_cmd_arbiter.sv
// Shares the flash_spi command port between the image writer (port 0) and
// the readback/debug reader (port 1). Inserts WREN ahead of program/erase
// opcodes and an idle gap after every SPI transaction.
//
// Handshake: a requester raises reqX with its cmd_typeX/cmdX/addrX stable
// and holds it until ackX; fields are captured only at the grant edge, and
// ackX is a single-cycle completion pulse even if reqX was dropped early.
// On the flash side, spi_* are held until spi_done is sampled high.
module flash_cmd_arbiter
  import flash_pkg::*;
#(
  parameter int GAP_CYCLES = 100,
  parameter int GAP_W      = 13
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req0,
  input  logic [3:0]          cmd_type0,
  input  logic [7:0]          cmd0,
  input  logic [23:0]         addr0,
  output logic                ack0,
  output logic [7:0]          rdata0,
  output logic                rvalid0,
  input  logic                req1,
  input  logic [3:0]          cmd_type1,
  input  logic [7:0]          cmd1,
  input  logic [23:0]         addr1,
  output logic                ack1,
  output logic [7:0]          rdata1,
  output logic                rvalid1,
  flash_cmd_arbiter_if.master spi,
  output logic                busy,
  output logic                owner,
  output state_t              state_dbg
);

  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  state_t            state;
  logic              last_grant;
  logic [GAP_W-1:0]  gap_cnt;
  logic [3:0]        sh_type;
  logic [7:0]        sh_cmd;
  logic [23:0]       sh_addr;
  logic [3:0]        spi_type_q;
  logic [7:0]        spi_cmd_q;
  logic [23:0]       spi_addr_q;

  logic              grant_valid;
  logic              grant_idx;
  logic [3:0]        sel_type;
  logic [7:0]        sel_cmd;
  logic [23:0]       sel_addr;

  flash_rr_pick u_pick (
    .req0        (req0),
    .req1        (req1),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // Fields of the port that would be granted this cycle.
  always_comb begin
    sel_type = grant_idx ? cmd_type1 : cmd_type0;
    sel_cmd  = grant_idx ? cmd1      : cmd0;
    sel_addr = grant_idx ? addr1     : addr0;
  end

  assign spi.spi_cmd_type = spi_type_q;
  assign spi.spi_cmd      = spi_cmd_q;
  assign spi.spi_addr     = spi_addr_q;
  assign state_dbg        = state;

  // Read data is broadcast; only the owner sees valid, and only during CMD.
  assign rdata0  = spi.spi_rdata;
  assign rdata1  = spi.spi_rdata;
  assign rvalid0 = spi.spi_rvalid & busy & (state == ST_CMD) & (owner == 1'b0);
  assign rvalid1 = spi.spi_rvalid & busy & (state == ST_CMD) & (owner == 1'b1);

  // Arbitration and sequencing FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      last_grant <= 1'b1;
      gap_cnt    <= '0;
      sh_type    <= CT_IDLE;
      sh_cmd     <= 8'h00;
      sh_addr    <= 24'h0;
      spi_type_q <= CT_IDLE;
      spi_cmd_q  <= 8'h00;
      spi_addr_q <= 24'h0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      busy       <= 1'b0;
      owner      <= 1'b0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant_valid) begin
            owner      <= grant_idx;
            last_grant <= grant_idx;
            sh_type    <= sel_type;
            sh_cmd     <= sel_cmd;
            sh_addr    <= sel_addr;
            busy       <= 1'b1;
            state      <= needs_wren(sel_cmd) ? ST_WREN : ST_CMD;
          end
        end
        ST_WREN: begin
          if (spi.spi_done) begin
            spi_type_q <= CT_IDLE;
            spi_cmd_q  <= 8'h00;
            spi_addr_q <= 24'h0;
            gap_cnt    <= '0;
            state      <= ST_WGAP;
          end else begin
            spi_type_q <= CT_CMD;
            spi_cmd_q  <= OP_WREN;
            spi_addr_q <= 24'h0;
          end
        end
        ST_WGAP: begin
          if (gap_cnt == GAP_LAST) begin
            state <= ST_CMD;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        ST_CMD: begin
          if (spi.spi_done) begin
            spi_type_q <= CT_IDLE;
            spi_cmd_q  <= 8'h00;
            spi_addr_q <= 24'h0;
            ack0       <= (owner == 1'b0);
            ack1       <= (owner == 1'b1);
            gap_cnt    <= '0;
            state      <= ST_GAP;
          end else begin
            spi_type_q <= sh_type;
            spi_cmd_q  <= sh_cmd;
            spi_addr_q <= sh_addr;
          end
        end
        ST_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/flash_cmd_arbiter.md
Name: flash_cmd_arbiter

Overview:
- Shares the single flash_spi command port between two requesters: port 0 is the image writer and port 1 is the image readback/debug reader.
- Each requester posts a command (type, opcode, address) and holds it until acked.
- The arbiter grants round-robin and automatically prefixes Write Enable (0x06) to program/erase opcodes.
- After every SPI transaction it inserts a fixed idle gap.
- It runs in the clk24M domain, between the requesters and flash_spi.

Parameters:
GAP_CYCLES, 100, idle cycles after every completed SPI transaction (WREN and main command)
GAP_W, 13, width of the gap counter; must hold GAP_CYCLES

Ports:
clk  in  1  24 MHz clock (same clock as flash_spi)
rst  in  1  synchronous active-high reset
req0  in  1  port 0 command request; held high until ack0
cmd_type0  in  4  port 0 flash_spi cmd_type (bit3 = execute)
cmd0  in  8  port 0 opcode
addr0  in  24  port 0 address
ack0  out  1  one-cycle pulse when port 0 command completes
rdata0  out  8  read data to port 0
rvalid0  out  1  read data valid to port 0
req1, cmd_type1, cmd1, addr1, ack1, rdata1, rvalid1  same as port 0, for port 1
spi_cmd_type  out  4  to flash_spi cmd_type
spi_cmd  out  8  to flash_spi flash_cmd
spi_addr  out  24  to flash_spi flash_addr
spi_done  in  1  flash_spi Done_Sig
spi_rdata  in  8  flash_spi mydata_o
spi_rvalid  in  1  flash_spi myvalid_o
busy  out  1  high in any state other than IDLE
owner  out  1  index of the granted port (valid while busy)

Behaviour:
- Clock and reset: all registers update on posedge clk.
- Reset values: state=IDLE, spi_cmd_type=0, spi_cmd=0, spi_addr=0, ack0=ack1=0, busy=0, owner=0, last_grant=1 (so port 0 wins first), gap counter=0. This includes reset mid-transaction: outputs return to 0 on the next edge and no ack is issued.
- States: IDLE, WREN, WGAP, CMD, GAP.
- IDLE:
  - If exactly one req is high, grant it.
  - If both are high, grant the port != last_grant.
  - On grant: latch owner and the port's cmd_type/cmd/addr into shadow registers; set last_grant=owner.
  - Go to WREN if the latched cmd is 0x02, 0x20, 0xD8 or 0xC7; otherwise go to CMD.
  - Grant decision takes 1 cycle: req seen at edge N gives spi_cmd_type driven at edge N+1.
- WREN: drive spi_cmd_type=4'b1001, spi_cmd=0x06, spi_addr=0. When spi_done is sampled high, drive all spi_* to 0 and go to WGAP.
- WGAP: count GAP_CYCLES cycles with spi_* at 0, then go to CMD.
- CMD:
  - Drive the shadow cmd_type/cmd/addr.
  - When spi_done is sampled high: drive spi_* to 0, pulse ack[owner] for exactly 1 cycle, go to GAP.
- GAP: count GAP_CYCLES cycles, then go to IDLE. No new grant is made before the gap expires.
- Read data path:
  - rdata0 = rdata1 = spi_rdata (combinational).
  - rvalidX = spi_rvalid & busy & state==CMD & owner==X. The non-owner never sees rvalid.
- Requester rules:
  - req and its fields are sampled only at grant; later changes are ignored.
  - Dropping req before ack does not abort the command; ack is still pulsed.
  - A requester that keeps req high after ack is eligible again at the next IDLE, but loses a tie to the other port.
- spi_done outside WREN/CMD is ignored.
- The gap counter resets to 0 on entry to WGAP and GAP; the exit condition is count==GAP_CYCLES-1.
- No timeout: a hung flash_spi leaves the arbiter in WREN or CMD until rst.

Decomposition:
- Shared package flash_pkg:
  - state encodings (IDLE/WREN/WGAP/CMD/GAP)
  - cmd_type constants CT_IDLE=4'b0000, CT_CMD=4'b1001, CT_PROG=4'b1101
  - opcode constants OP_WREN=0x06, OP_PP=0x02, OP_SE=0x20, OP_BE=0xD8, OP_CE=0xC7, OP_READ=0x03
  - function needs_wren(op)
- One natural sub-module: flash_rr_pick, a 2-way round-robin grant (req0, req1, last_grant -> grant_valid, grant_idx). Everything else stays in flash_cmd_arbiter.

Test Plan:
- Port 0 only, req0 with cmd0=0x03, addr0=0x000280; model asserts spi_done 40 cycles later. Expect: spi_cmd=0x03 and spi_addr=0x000280 one cycle after req0, with no WREN. Expect rvalid0 to follow spi_rvalid and rvalid1 to stay 0. Expect ack0 pulsed once, then GAP for 100 cycles before the next grant.
- Port 1, cmd1=0x02, cmd_type1=1101, addr1=0x001000. Expect the sequence spi_cmd=0x06/1001 until done, then 100 idle cycles, then 0x02/1101 at addr 0x001000. Expect ack1 exactly once.
- req0 and req1 rise on the same edge after reset. Expect port 0 granted first and port 1 granted right after port 0's GAP. With both held continuously, grants alternate 0,1,0,1.
- req0 dropped mid-CMD, and cmd0/addr0 changed mid-CMD. Expect spi_cmd/spi_addr unchanged and ack0 still pulsed.
- rst asserted during WGAP of an erase (cmd 0x20). Expect all spi_* at 0 on the next edge, busy=0, no ack. After release, a held req0 re-grants and WREN is reissued.
- spi_done pulsed in IDLE and in GAP. Expect no state change and no ack.
